// File: rtl/bus_if_wb.sv
// rtl/bus_if_wb.sv - CPU bus interface: SPM routing, posted-write buffer, bus engine with watchdog
module bus_if_wb #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 3,
    parameter int LOCAL_IDX  = 1,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              bus_err_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              as_n_i,
    input  logic              rw_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [DATA_W-1:0] spm_rd_data_i,
    output logic [ADDR_W-1:0] spm_addr_o,
    output logic              spm_as_n_o,
    output logic              spm_rw_o,
    output logic [DATA_W-1:0] spm_wr_data_o,
    input  logic [DATA_W-1:0] bus_rd_data_i,
    input  logic              bus_rdy_n_i,
    input  logic              bus_grnt_n_i,
    output logic              bus_req_n_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_as_n_o,
    output logic              bus_rw_o,
    output logic [DATA_W-1:0] bus_wr_data_o
);
    localparam int   PTR_W = $clog2(WBUF_DEPTH);
    localparam int   CNT_W = PTR_W + 1;
    localparam int   WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {E_IDLE, E_REQ, E_ACCESS, E_STALL} e_state_t;

    e_state_t          state_q, state_d;
    logic              bus_req_n_q, bus_req_n_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_as_n_q, bus_as_n_d;
    logic              bus_rw_q, bus_rw_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [IDX_W-1:0]  idx;
    logic              req_valid, is_local, rd_req, wr_req;
    logic              wb_full, wb_empty, serving_read, push, pop;
    logic              acc_timeout, acc_done, rd_done;
    logic [DATA_W-1:0] rd_fresh;

    assign idx       = addr_i[ADDR_W-1 -: IDX_W];
    assign req_valid = !as_n_i && !flush_i;
    assign is_local  = (idx == IDX_W'(LOCAL_IDX));
    assign rd_req    = req_valid && !is_local && rw_i;
    assign wr_req    = req_valid && !is_local && !rw_i;

    assign wb_full      = (cnt_q == CNT_W'(WBUF_DEPTH));
    assign wb_empty     = (cnt_q == '0);
    assign serving_read = (state_q != E_IDLE) && (bus_rw_q == READ);
    // Full uses the registered count, so a pop in this cycle does not admit a push.
    assign push         = wr_req && !stall_i && !wb_full && !serving_read;

    assign acc_timeout = (TIMEOUT != 0) && (state_q == E_ACCESS) && bus_rdy_n_i &&
                         (wd_q == WD_W'(TIMEOUT - 1));
    assign acc_done    = (state_q == E_ACCESS) && (!bus_rdy_n_i || acc_timeout);
    assign rd_done     = acc_done && (bus_rw_q == READ);
    assign rd_fresh    = acc_timeout ? '0 : bus_rd_data_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            wb_addr_q[tail_q] <= addr_i;
            wb_data_q[tail_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= E_IDLE;
            bus_req_n_q   <= 1'b1;
            bus_addr_q    <= '0;
            bus_as_n_q    <= 1'b1;
            bus_rw_q      <= READ;
            bus_wr_data_q <= '0;
            bus_err_q     <= 1'b0;
            rd_buf_q      <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_n_q   <= bus_req_n_d;
            bus_addr_q    <= bus_addr_d;
            bus_as_n_q    <= bus_as_n_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_err_q     <= bus_err_d;
            rd_buf_q      <= rd_buf_d;
            wd_q          <= wd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus_req_n_d   = bus_req_n_q;
        bus_addr_d    = bus_addr_q;
        bus_as_n_d    = 1'b1;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_err_d     = 1'b0;
        rd_buf_d      = rd_buf_q;
        wd_d          = wd_q;
        pop           = 1'b0;
        case (state_q)
            E_IDLE: begin
                // Draining writes first keeps a later read ordered behind them.
                if (!wb_empty) begin
                    bus_addr_d    = wb_addr_q[head_q];
                    bus_wr_data_d = wb_data_q[head_q];
                    bus_rw_d      = WRITE;
                    bus_req_n_d   = 1'b0;
                    state_d       = E_REQ;
                end else if (rd_req) begin
                    bus_addr_d    = addr_i;
                    bus_rw_d      = READ;
                    bus_req_n_d   = 1'b0;
                    state_d       = E_REQ;
                end
            end
            E_REQ: begin
                if (!bus_grnt_n_i) begin
                    bus_as_n_d = 1'b0;
                    state_d    = E_ACCESS;
                end
            end
            E_ACCESS: begin
                wd_d = wd_q + 1'b1;
                if (acc_done) begin
                    bus_req_n_d   = 1'b1;
                    bus_addr_d    = '0;
                    bus_rw_d      = READ;
                    bus_wr_data_d = '0;
                    wd_d          = '0;
                    bus_err_d     = acc_timeout;
                    if (bus_rw_q == WRITE) begin
                        pop     = 1'b1;
                        state_d = E_IDLE;
                    end else begin
                        rd_buf_d = rd_fresh;
                        state_d  = stall_i ? E_STALL : E_IDLE;
                    end
                end
            end
            E_STALL: begin
                if (!stall_i) state_d = E_IDLE;
            end
            default: state_d = E_IDLE;
        endcase
    end

    always_comb begin
        rd_data_o  = '0;
        spm_as_n_o = 1'b1;
        busy_o     = 1'b0;
        if (rd_done) begin
            rd_data_o = rd_fresh;
        end else if (state_q == E_STALL) begin
            rd_data_o = rd_buf_q;
        end
        if (req_valid) begin
            if (is_local) begin
                spm_as_n_o = stall_i;
                if (rw_i) rd_data_o = spm_rd_data_i;
            end else if (rw_i) begin
                busy_o = !(rd_done || (state_q == E_STALL));
            end else begin
                busy_o = wb_full || serving_read;
            end
        end
    end

    assign spm_addr_o    = addr_i;
    assign spm_rw_o      = rw_i;
    assign spm_wr_data_o = wr_data_i;
    assign bus_req_n_o   = bus_req_n_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_as_n_o    = bus_as_n_q;
    assign bus_rw_o      = bus_rw_q;
    assign bus_wr_data_o = bus_wr_data_q;
    assign bus_err_o     = bus_err_q;
endmodule

// File: tb/tb_bus_if_wb.sv
// tb/tb_bus_if_wb.sv - scoreboard bench for bus_if_wb with a request/grant bus slave model
module tb_bus_if_wb;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        bus_err_o;
    logic [29:0] addr_i = '0;
    logic        as_n_i = 1'b1;
    logic        rw_i = 1'b1;
    logic [31:0] wr_data_i = '0;
    logic [31:0] rd_data_o;
    logic [31:0] spm_rd_data_i = '0;
    logic [29:0] spm_addr_o;
    logic        spm_as_n_o;
    logic        spm_rw_o;
    logic [31:0] spm_wr_data_o;
    logic [31:0] bus_rd_data_i = 32'h0BAD_0BAD;
    logic        bus_rdy_n_i = 1'b1;
    logic        bus_grnt_n_i = 1'b1;
    logic        bus_req_n_o;
    logic [29:0] bus_addr_o;
    logic        bus_as_n_o;
    logic        bus_rw_o;
    logic [31:0] bus_wr_data_o;

    typedef struct packed {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] data;
    } bus_op_t;

    bus_op_t     bus_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          grant_en = 1'b0;
    bit          rdy_never = 1'b0;
    int          rdy_delay = 0;
    logic [31:0] rd_val = '0;
    bit          in_acc = 1'b0;
    bit          gap_seen = 1'b1;
    int          acc_cnt = 0;

    localparam logic [29:0] REM = 30'h1000_0000;

    bus_if_wb #(
        .ADDR_W(30), .DATA_W(32), .IDX_W(3), .LOCAL_IDX(1), .WBUF_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
        .busy_o(busy_o), .bus_err_o(bus_err_o), .addr_i(addr_i), .as_n_i(as_n_i),
        .rw_i(rw_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o),
        .spm_rd_data_i(spm_rd_data_i), .spm_addr_o(spm_addr_o), .spm_as_n_o(spm_as_n_o),
        .spm_rw_o(spm_rw_o), .spm_wr_data_o(spm_wr_data_o), .bus_rd_data_i(bus_rd_data_i),
        .bus_rdy_n_i(bus_rdy_n_i), .bus_grnt_n_i(bus_grnt_n_i), .bus_req_n_o(bus_req_n_o),
        .bus_addr_o(bus_addr_o), .bus_as_n_o(bus_as_n_o), .bus_rw_o(bus_rw_o),
        .bus_wr_data_o(bus_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus slave: grants on request, checks each strobed op against the scoreboard, returns rdy.
    always @(posedge clk_i) begin
        bus_op_t exp_op;
        #2;
        bus_rdy_n_i   = 1'b1;
        bus_rd_data_i = 32'h0BAD_0BAD;
        bus_grnt_n_i  = !(grant_en && !bus_req_n_o);
        if (bus_req_n_o) begin
            in_acc   = 1'b0;
            gap_seen = 1'b1;
        end
        if (!bus_as_n_o) begin
            chk("bus_gap", 64'(gap_seen), 64'd1);
            gap_seen = 1'b0;
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 64'd1, 64'd0);
            end else begin
                exp_op = bus_q.pop_front();
                chk("bus_op", {1'b0, bus_rw_o, bus_addr_o, bus_wr_data_o}, {1'b0, exp_op});
            end
            in_acc  = 1'b1;
            acc_cnt = 0;
        end
        if (in_acc) begin
            if (!rdy_never && acc_cnt == rdy_delay) begin
                bus_rdy_n_i   = 1'b0;
                bus_rd_data_i = rd_val;
                in_acc        = 1'b0;
            end
            acc_cnt++;
        end
    end

    task automatic cpu_idle();
        @(posedge clk_i); #1;
        as_n_i = 1'b1; rw_i = 1'b1; flush_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic cpu_write(input logic [29:0] a, input logic [31:0] d, output int waits);
        @(posedge clk_i); #1;
        as_n_i = 1'b0; rw_i = 1'b0; addr_i = a; wr_data_i = d;
        bus_q.push_back({1'b0, a, d});
        waits = 0;
        @(negedge clk_i);
        while (busy_o && waits < 60) begin
            waits++;
            @(negedge clk_i);
        end
        if (busy_o) chk("wr_wait_bound", 64'd1, 64'd0);
    endtask

    task automatic cpu_read(input logic [29:0] a, input logic [31:0] exp, output int waits);
        @(posedge clk_i); #1;
        as_n_i = 1'b0; rw_i = 1'b1; addr_i = a;
        bus_q.push_back({1'b1, a, 32'h0});
        waits = 0;
        @(negedge clk_i);
        chk("rd_busy_start", 64'(busy_o), 64'd1);
        while (busy_o && waits < 60) begin
            waits++;
            @(negedge clk_i);
        end
        if (busy_o) chk("rd_wait_bound", 64'd1, 64'd0);
        chk("rd_data", 64'(rd_data_o), 64'(exp));
    endtask

    initial begin
        int w;
        int low_seen;
        #3 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_outs", {bus_req_n_o, bus_as_n_o, bus_rw_o, bus_err_o, busy_o, spm_as_n_o},
            {58'd0, 6'b111001});
        chk("rst_bus_addr", 64'(bus_addr_o), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wr_data_o), 64'd0);
        chk("rst_rd_data", 64'(rd_data_o), 64'd0);

        // Local read and write to the SPM
        @(posedge clk_i); #1;
        as_n_i = 1'b0; rw_i = 1'b1; addr_i = 30'h0800_0010; spm_rd_data_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        chk("loc_rd", {spm_as_n_o, busy_o, bus_req_n_o, spm_addr_o, rd_data_o},
            {1'b0, 1'b0, 1'b1, 30'h0800_0010, 32'hCAFE_F00D});
        @(posedge clk_i); #1;
        rw_i = 1'b0; wr_data_i = 32'h1357_9BDF;
        @(negedge clk_i);
        chk("loc_wr", {spm_as_n_o, busy_o, spm_rw_o, spm_wr_data_o}, {1'b0, 1'b0, 1'b0, 32'h1357_9BDF});
        cpu_idle();

        // Four posted writes with grant withheld, fifth stalls on a full buffer
        grant_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(REM | 30'(i * 4), 32'hD000_0000 + 32'(i), w);
            chk("wr_posted", 64'(w), 64'd0);
        end
        grant_en = 1'b1; rdy_delay = 2;
        cpu_write(REM | 30'h40, 32'hD000_0004, w);
        chk("wr_full_busy", 64'(w != 0), 64'd1);
        cpu_idle();
        for (int i = 0; i < 300 && !(bus_q.size() == 0 && bus_req_n_o); i++) @(negedge clk_i);
        chk("drain", 64'(bus_q.size()), 64'd0);

        // Read-after-write ordering
        rdy_delay = 1; rd_val = 32'h0000_1234;
        cpu_write(REM | 30'h100, 32'h0000_1234, w);
        cpu_read(REM | 30'h100, 32'h0000_1234, w);
        chk("raw_wait", 64'(w > 2), 64'd1);
        cpu_idle();

        // Read completing under stall is held in E_STALL
        rdy_delay = 0; rd_val = 32'hA5A5_A5A5; stall_i = 1'b1;
        cpu_read(REM | 30'h200, 32'hA5A5_A5A5, w);
        chk("stall_rd_wait", 64'(w), 64'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_hold", {busy_o, rd_data_o}, {1'b0, 32'hA5A5_A5A5});
        end
        @(posedge clk_i); #1;
        stall_i = 1'b0;
        @(negedge clk_i);
        chk("stall_rel", {busy_o, rd_data_o}, {1'b0, 32'hA5A5_A5A5});
        cpu_idle();
        chk("stall_idle", {bus_req_n_o, rd_data_o}, {1'b1, 32'h0});

        // Watchdog timeout on a read
        rdy_never = 1'b1;
        cpu_read(REM | 30'h300, 32'h0, w);
        chk("to_wait", 64'(w), 64'd9);
        chk("to_err_early", 64'(bus_err_o), 64'd0);
        cpu_idle();
        chk("to_err", {bus_err_o, bus_req_n_o}, {1'b1, 1'b1});
        cpu_idle();
        chk("to_err_pulse", 64'(bus_err_o), 64'd0);
        rdy_never = 1'b0;

        // A flushed remote write has no effect
        @(posedge clk_i); #1;
        as_n_i = 1'b0; rw_i = 1'b0; flush_i = 1'b1; addr_i = REM | 30'h400;
        @(negedge clk_i);
        chk("flush_busy", 64'(busy_o), 64'd0);
        low_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_idle();
            if (!bus_req_n_o) low_seen++;
        end
        chk("flush_noop", 64'(low_seen), 64'd0);

        // Reset during ACCESS with buffered writes
        rdy_never = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(REM | 30'(16 * i), 32'hE000_0000 + 32'(i), w);
        cpu_idle();
        @(posedge clk_i); #1;
        chk("pre_rst_req", 64'(bus_req_n_o), 64'd0);
        rst_ni = 1'b0;
        #1;
        chk("rst_async", {bus_req_n_o, bus_as_n_o, bus_addr_o}, {1'b1, 1'b1, 30'h0});
        bus_q.delete();
        rdy_never = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        low_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (!bus_req_n_o) low_seen++;
        end
        chk("rst_flushed", 64'(low_seen), 64'd0);
        rd_val = 32'h5555_AAAA;
        cpu_read(REM | 30'h500, 32'h5555_AAAA, w);
        chk("rst_empty_rd", 64'(w), 64'd2);
        cpu_idle();
        cpu_idle();
        chk("end_queue", 64'(bus_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
